// File: rtl/nms_suppress_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nms_suppress_if                                                      |
// | Pixel stream in (mag + direction) and suppressed pixel stream out.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface nms_suppress_if;
  logic       inValid;
  logic       inReady;
  logic [7:0] inMag;
  logic [7:0] inDir;
  logic       outValid;
  logic [7:0] outMag;
  logic [7:0] outDir;
  logic       frameDone;

  modport master (
    output inValid, inMag, inDir,
    input  inReady, outValid, outMag, outDir, frameDone
  );

  modport slave (
    input  inValid, inMag, inDir,
    output inReady, outValid, outMag, outDir, frameDone
  );
endinterface
`default_nettype wire

// File: rtl/nms_suppress.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nms_suppress                                                         |
// | 3x3 non-maximum suppression along the quantised gradient direction.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nms_suppress #(
  parameter int WIDTH     = 512,
  parameter int HEIGHT    = 1024,
  parameter int LOWTHRESH = 0,
  parameter int CW        = 10,
  parameter int RW        = 10
) (
  input  wire logic     clk,
  input  wire logic     reset,
  nms_suppress_if.slave bus
);

  localparam int             c_AW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_LASTCOL   = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  c_LASTROW   = RW'(HEIGHT - 1);
  localparam logic [RW-1:0]  c_ROW1      = RW'(1);
  localparam logic [CW-1:0]  c_COL1      = CW'(1);
  localparam logic [CW:0]    c_FLUSHLAST = (CW+1)'(WIDTH);
  localparam logic [7:0]     c_THRESH    = 8'(LOWTHRESH);
  localparam logic [7:0]     c_DIR0      = 8'd0;
  localparam logic [7:0]     c_DIR45     = 8'd45;
  localparam logic [7:0]     c_DIR90     = 8'd90;
  localparam logic [7:0]     c_DIR135    = 8'd135;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_ready;
  logic          w_acc;
  logic          w_adv;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW:0]   r_fcnt;

  logic [15:0]   r_lb1 [WIDTH];
  logic [7:0]    r_lb2 [WIDTH];
  logic [15:0]   w_pix;
  logic [15:0]   w_up1;
  logic [7:0]    w_up2;

  // Window columns c-1 and c are registered; column c+1 is the incoming beat
  logic [7:0]    r_lmag [3];
  logic [7:0]    r_cmag [3];
  logic [7:0]    r_cdir;
  logic [7:0]    w_nmag [3];

  logic [7:0]    w_na;
  logic [7:0]    w_nb;
  logic [7:0]    w_c;
  logic          w_border;
  logic          w_keep;

  logic          r_out_valid;
  logic [7:0]    r_out_mag;
  logic [7:0]    r_out_dir;
  logic          r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = ~reset & (r_state != S_FLUSH);
    w_acc       = bus.inValid & w_ready;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_FILL;
      S_FILL:  if (w_acc && r_row == c_ROW1 && r_col == '0) w_state_nxt = S_RUN;
      S_RUN:   if (w_acc && r_row == c_LASTROW && r_col == c_LASTCOL) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_fcnt == c_FLUSHLAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flush cycles act as virtual zero beats so the last centres drain out
  assign w_adv = ~reset & (w_acc | (r_state == S_FLUSH));
  assign w_pix = (r_state == S_FLUSH) ? 16'h0000 : {bus.inMag, bus.inDir};
  assign w_up1 = r_lb1[r_col[c_AW-1:0]];
  assign w_up2 = r_lb2[r_col[c_AW-1:0]];

  assign w_nmag[0] = w_up2;
  assign w_nmag[1] = w_up1[15:8];
  assign w_nmag[2] = w_pix[15:8];

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb1[r_col[c_AW-1:0]] <= w_pix;
      r_lb2[r_col[c_AW-1:0]] <= w_up1[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lmag <= '{default: 8'h00};
      r_cmag <= '{default: 8'h00};
      r_cdir <= 8'h00;
    end else if (w_adv) begin
      r_lmag <= r_cmag;
      r_cmag <= w_nmag;
      r_cdir <= w_up1[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_fcnt <= '0;
    end else if (r_state == S_FLUSH) begin
      if (r_fcnt == c_FLUSHLAST) begin
        r_col  <= '0;
        r_row  <= '0;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
        r_col  <= (r_col == c_LASTCOL) ? '0 : r_col + 1'b1;
      end
    end else if (w_acc) begin
      r_col <= (r_col == c_LASTCOL) ? '0 : r_col + 1'b1;
      if (r_col == c_LASTCOL)
        r_row <= (r_row == c_LASTROW) ? '0 : r_row + 1'b1;
    end
  end

  always_comb begin
    w_c  = r_cmag[1];
    w_na = r_lmag[1];
    w_nb = w_nmag[1];
    case (r_cdir)
      c_DIR0, c_DIR90: begin
        w_na = r_cmag[0];
        w_nb = r_cmag[2];
      end
      c_DIR45: begin
        w_na = w_nmag[0];
        w_nb = r_lmag[2];
      end
      c_DIR135: begin
        w_na = r_lmag[0];
        w_nb = w_nmag[2];
      end
      default: begin
        w_na = r_lmag[1];
        w_nb = w_nmag[1];
      end
    endcase
  end

  // Centre sits one row up and one column left of the incoming beat
  assign w_border = (r_row == c_ROW1) | (r_col == '0) | (r_col == c_COL1);
  assign w_keep   = ~w_border & (w_c >= w_na) & (w_c >= w_nb) & (w_c > c_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_mag    <= 8'h00;
      r_out_dir    <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= (r_state == S_RUN && w_acc) || (r_state == S_FLUSH);
      r_frame_done <= (r_state == S_FLUSH) && (r_fcnt == c_FLUSHLAST);
      if ((r_state == S_RUN && w_acc) || (r_state == S_FLUSH)) begin
        r_out_mag <= (r_state == S_RUN && w_keep) ? w_c : 8'h00;
        r_out_dir <= r_cdir;
      end
    end
  end

  assign bus.inReady   = w_ready;
  assign bus.outValid  = r_out_valid;
  assign bus.outMag    = r_out_mag;
  assign bus.outDir    = r_out_dir;
  assign bus.frameDone = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_nms_suppress.sv
`default_nettype none
// Bench for nms_suppress: two instances (threshold 0 and 60) share one
// stimulus stream and are checked every cycle against a frame-level model.
module tb_nms_suppress;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int NF = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inValid = 1'b0;
  logic [7:0] inMag = 8'h00;
  logic [7:0] inDir = 8'h00;

  always #5 clk = ~clk;

  nms_suppress_if b0 ();
  nms_suppress_if b1 ();

  assign b0.inValid = inValid;
  assign b0.inMag   = inMag;
  assign b0.inDir   = inDir;
  assign b1.inValid = inValid;
  assign b1.inMag   = inMag;
  assign b1.inDir   = inDir;

  nms_suppress #(.WIDTH(W), .HEIGHT(H), .LOWTHRESH(0), .CW(3), .RW(2)) dut0 (
    .clk(clk), .reset(reset), .bus(b0));
  nms_suppress #(.WIDTH(W), .HEIGHT(H), .LOWTHRESH(60), .CW(3), .RW(2)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));

  int total = 0;
  int bad   = 0;

  logic [7:0] pm [N];
  logic [7:0] pd [N];
  logic [7:0] fmag [N];
  logic [7:0] fdir [N];

  int got0 [NF][N];
  int got1 [NF][N];
  int fcnt [NF];
  int fi = 0;
  int oi = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expmag(input int i, input int thr);
    int r, c;
    logic [7:0] cm, a, b;
    r = i / W;
    c = i % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
    cm = fmag[i];
    case (fdir[i])
      8'd0, 8'd90: begin a = fmag[i-W];   b = fmag[i+W];   end
      8'd45:       begin a = fmag[i-W+1]; b = fmag[i+W-1]; end
      8'd135:      begin a = fmag[i-W-1]; b = fmag[i+W+1]; end
      default:     begin a = fmag[i-1];   b = fmag[i+1];   end
    endcase
    return (cm >= a && cm >= b && int'(cm) > thr) ? cm : 8'd0;
  endfunction

  // Model: accepted-beat count and remaining flush beats per frame
  initial begin
    int k = 0;
    int flush_left = 0;
    int ci;
    bit ev, efd, jr, er;
    logic [7:0] em0, em1, ed;
    forever begin
      @(posedge clk);
      ev = 0; efd = 0; jr = 0; em0 = 0; em1 = 0; ed = 0;
      if (reset) begin
        k = 0; flush_left = 0; jr = 1;
      end else if (flush_left > 0) begin
        ci = N - flush_left;
        ev = 1; em0 = expmag(ci, 0); em1 = expmag(ci, 60); ed = fdir[ci];
        flush_left--;
        efd = (flush_left == 0);
      end else if (inValid) begin
        fmag[k] = inMag;
        fdir[k] = inDir;
        if (k >= W + 1) begin
          ci = k - W - 1;
          ev = 1; em0 = expmag(ci, 0); em1 = expmag(ci, 60); ed = fdir[ci];
        end
        k++;
        if (k == N) begin
          k = 0; flush_left = W + 1;
        end
      end
      er = !reset && flush_left == 0;
      #1;
      chk("ready0", int'(b0.inReady), int'(er));
      chk("ready1", int'(b1.inReady), int'(er));
      chk("valid0", int'(b0.outValid), int'(ev));
      chk("valid1", int'(b1.outValid), int'(ev));
      chk("fdone0", int'(b0.frameDone), int'(efd));
      chk("fdone1", int'(b1.frameDone), int'(efd));
      if (ev) begin
        chk("mag0", int'(b0.outMag), int'(em0));
        chk("mag1", int'(b1.outMag), int'(em1));
        chk("dir0", int'(b0.outDir), int'(ed));
        chk("dir1", int'(b1.outDir), int'(ed));
      end
      if (jr) begin
        chk("rst_mag0", int'(b0.outMag), 0);
        chk("rst_dir0", int'(b0.outDir), 0);
        chk("rst_mag1", int'(b1.outMag), 0);
        oi = 0;
      end
      if (b0.outValid) begin
        if (fi < NF && oi < N) begin
          got0[fi][oi] = int'(b0.outMag);
          got1[fi][oi] = int'(b1.outMag);
        end
        oi++;
      end
      if (b0.frameDone) begin
        if (fi < NF) fcnt[fi] = oi;
        fi++;
        oi = 0;
      end
    end
  end

  task automatic set_all(input logic [7:0] m, input logic [7:0] d);
    for (int i = 0; i < N; i++) begin
      pm[i] = m;
      pd[i] = d;
    end
  endtask

  task automatic send(input bit gappy, input int count);
    int i = 0;
    int guard = 0;
    while (i < count) begin
      @(negedge clk);
      inValid = !gappy || ($urandom_range(0, 2) != 0);
      inMag = pm[i];
      inDir = pd[i];
      #1;
      if (inValid && b0.inReady) i++;
      guard++;
      if (guard > 2000) begin
        chk("send_timeout", i, count);
        break;
      end
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g = 0;
    while (fi < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("frames_seen", fi, n);
  endtask

  task automatic check_uniform(input int f);
    int n50 = 0;
    int n0 = 0;
    for (int i = 0; i < N; i++) begin
      if (got0[f][i] == 50) n50++;
      if (got0[f][i] == 0) n0++;
    end
    chk("uni_count", fcnt[f], 32);
    chk("uni_kept50", n50, 12);
    chk("uni_zero", n0, 20);
    chk("uni_c9", got0[f][9], 50);
    chk("uni_c0", got0[f][0], 0);
  endtask

  initial begin
    logic [7:0] dset [6];
    logic [7:0] dirs [4];
    int rexp [4];
    dset = '{8'd0, 8'd10, 8'd45, 8'd90, 8'd135, 8'd200};
    dirs = '{8'd45, 8'd10, 8'd135, 8'd200};
    rexp = '{0, 100, 100, 100};
    for (int f = 0; f < NF; f++) begin
      fcnt[f] = -1;
      for (int i = 0; i < N; i++) begin
        got0[f][i] = -1;
        got1[f][i] = -1;
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    set_all(8'd50, 8'd10);
    send(1'b0, N);
    wait_frames(1);
    check_uniform(0);

    set_all(8'd0, 8'd90);
    pm[11] = 8'd200;
    send(1'b0, N);
    wait_frames(2);
    chk("peak_c11", got0[1][11], 200);
    chk("peak_c19", got0[1][19], 0);
    chk("peak_count", fcnt[1], 32);

    for (int t = 0; t < 4; t++) begin
      set_all(8'd0, 8'd10);
      pm[2] = 8'd70;  pm[3] = 8'd50;   pm[4] = 8'd120;
      pm[10] = 8'd80; pm[11] = 8'd100; pm[12] = 8'd80;
      pm[18] = 8'd90; pm[19] = 8'd50;  pm[20] = 8'd70;
      pd[11] = dirs[t];
      send(1'b0, N);
      wait_frames(3 + t);
      chk("dirsel_c11", got0[2+t][11], rexp[t]);
    end

    set_all(8'd0, 8'd10);
    pm[11] = 8'd60;
    pm[21] = 8'd61;
    send(1'b0, N);
    wait_frames(7);
    chk("thr0_c11", got0[6][11], 60);
    chk("thr60_c11", got1[6][11], 0);
    chk("thr60_c21", got1[6][21], 61);
    chk("thr0_c21", got0[6][21], 61);

    for (int i = 0; i < N; i++) begin
      pm[i] = 8'($urandom_range(0, 255));
      pd[i] = dset[$urandom_range(0, 5)];
    end
    send(1'b1, N);
    for (int i = 0; i < N; i++) pm[i] = 8'($urandom_range(0, 255));
    send(1'b1, N);
    wait_frames(9);
    chk("hs_count_a", fcnt[7], 32);
    chk("hs_count_b", fcnt[8], 32);

    set_all(8'd50, 8'd10);
    send(1'b0, 21);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_frame", fi, 9);
    send(1'b0, N);
    wait_frames(10);
    check_uniform(9);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
